dct_ctrl: RTL and testbench

Input sequencer for the 8×8 DCT datapath (`dct`). Accepts pixels in raster order over a valid/ready stream and buffers them in a two-bank ping-pong store. Replays each buffered block twice into the datapath's unthrottled `x`/`sumDiffSel`/`load` inputs: a sum pass, then a difference pass, in butterfly column order. Counts datapath `valid` pulses to flag block completion.

---
 rtl/dct_pkg.sv | 21 ++
 rtl/pingpong_buf.sv | 42 ++++
 rtl/dct_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dct_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT input sequencer.
package dct_pkg;

    localparam int unsigned BLK_N    = 8;
    localparam int unsigned BLK_SIZE = 64;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StDiff
    } feed_state_e;

    // Butterfly column order: k = 0..7 -> columns 0,7,1,6,2,5,3,4.
    function automatic logic [2:0] bfly_col(input logic [2:0] k);
        if (k[0]) begin
            return 3'd7 - {1'b0, k[2:1]};
        end
        return {1'b0, k[2:1]};
    endfunction

endpackage

// File: rtl/pingpong_buf.sv
// Two-bank sample store: one write port, one read port with 1-cycle latency.
// The read data register returns zero on cycles without a read so idle output is clean.
module pingpong_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic                     i_wr_bank,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_re,
    input  logic                     i_rd_bank,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: bank select forms the address MSB.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dct_ctrl.sv
// DCT input sequencer: buffers raster pixels in a ping-pong store and replays each
// block as a sum pass then a difference pass in butterfly column order.
module dct_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OUT_PER_BLOCK = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] dct_x,
    output logic                  dct_sumDiffSel,
    output logic                  dct_load,
    output logic                  feed_active,
    input  logic                  dct_valid,
    output logic                  block_done,
    output logic                  busy
);

    import dct_pkg::*;

    localparam int unsigned AW = $clog2(BLK_SIZE);
    localparam int unsigned CW = $clog2(BLK_N);
    localparam int unsigned OW = $clog2(OUT_PER_BLOCK);
    localparam logic [AW-1:0] LAST_IDX = AW'(BLK_SIZE - 1);
    localparam logic [OW-1:0] LAST_OUT = OW'(OUT_PER_BLOCK - 1);

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_cnt;
    logic          r_rd_bank, w_rd_bank_d;
    logic [AW-1:0] r_rd_cnt, w_rd_cnt_d;
    feed_state_e   r_state, w_state_d;
    logic          r_load, r_sel, r_feed;
    logic [OW-1:0] r_out_cnt;
    logic          r_done;

    logic          w_wr_hs, w_wr_last;
    logic          w_rd_en, w_rd_release, w_next_full;
    logic [1:0]    w_full_set, w_full_clr;
    logic [AW-1:0] w_rd_addr;

    assign s_ready   = !rst && !r_full[r_wr_bank];
    assign w_wr_hs   = s_valid && s_ready;
    assign w_wr_last = w_wr_hs && (r_wr_cnt == LAST_IDX);
    assign w_rd_addr = {r_rd_cnt[AW-1:CW], bfly_col(r_rd_cnt[CW-1:0])};

    // A block finishing its write on the very edge DIFF ends still counts, so the
    // feed continues without an idle bubble.
    assign w_next_full = r_full[!r_rd_bank] || (w_wr_last && (r_wr_bank != r_rd_bank));

    assign w_full_set = w_wr_last    ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_rd_release ? (2'b01 << r_rd_bank) : 2'b00;

    // Write pointer and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_hs) begin
            r_wr_cnt <= r_wr_cnt + AW'(1);
            if (w_wr_last) begin
                r_wr_bank <= !r_wr_bank;
            end
        end
    end

    // Bank-full flags; write-side set and read-side clear always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // Read FSM state, read counter and read bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_rd_cnt  <= w_rd_cnt_d;
            r_rd_bank <= w_rd_bank_d;
        end
    end

    // Read FSM next state: SUM pass then DIFF pass over the same bank.
    always_comb begin
        w_state_d    = r_state;
        w_rd_cnt_d   = r_rd_cnt;
        w_rd_bank_d  = r_rd_bank;
        w_rd_en      = 1'b0;
        w_rd_release = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_full[r_rd_bank]) begin
                    w_state_d = StSum;
                end
            end
            StSum: begin
                w_rd_en    = 1'b1;
                w_rd_cnt_d = r_rd_cnt + AW'(1);
                if (r_rd_cnt == LAST_IDX) begin
                    w_state_d = StDiff;
                end
            end
            StDiff: begin
                w_rd_en    = 1'b1;
                w_rd_cnt_d = r_rd_cnt + AW'(1);
                if (r_rd_cnt == LAST_IDX) begin
                    w_rd_release = 1'b1;
                    w_rd_bank_d  = !r_rd_bank;
                    w_state_d    = w_next_full ? StSum : StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    pingpong_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BLK_SIZE)
    ) u_buf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (w_wr_hs),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (s_data),
        .i_re      (w_rd_en),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (dct_x)
    );

    // Side-band outputs delayed one stage to line up with the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feed <= 1'b0;
            r_load <= 1'b0;
            r_sel  <= 1'b0;
        end else begin
            r_feed <= w_rd_en;
            r_load <= w_rd_en && (r_rd_cnt[CW-1:0] == '0);
            r_sel  <= (r_state == StDiff);
        end
    end

    // Completion counter over datapath valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else if (dct_valid) begin
            if (r_out_cnt == LAST_OUT) begin
                r_out_cnt <= '0;
                r_done    <= 1'b1;
            end else begin
                r_out_cnt <= r_out_cnt + OW'(1);
                r_done    <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign feed_active    = r_feed;
    assign dct_load       = r_load;
    assign dct_sumDiffSel = r_sel;
    assign block_done     = r_done;
    assign busy           = (|r_full) || (r_state != StIdle);

endmodule

// File: tb/tb_dct_ctrl.sv
// Randomised bench for dct_ctrl with a block-level reference model.
module tb_dct_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] dct_x;
    logic       dct_sumDiffSel;
    logic       dct_load;
    logic       feed_active;
    logic       dct_valid;
    logic       block_done;
    logic       busy;

    always #5 clk = ~clk;

    dct_ctrl #(
        .DATA_WIDTH    (8),
        .OUT_PER_BLOCK (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .dct_x          (dct_x),
        .dct_sumDiffSel (dct_sumDiffSel),
        .dct_load       (dct_load),
        .feed_active    (feed_active),
        .dct_valid      (dct_valid),
        .block_done     (block_done),
        .busy           (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d got=timeout want=event", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Blocks are tracked as whole units: a count of stored blocks, a FIFO of their
    // pixels, and the position (0..127) within the two-pass replay.
    int col_order[8] = '{0, 7, 1, 6, 2, 5, 3, 4};
    int m_part[$];
    int m_pix[$];
    int m_rd_blk[64];
    int m_out_blk[64];
    int m_full   = 0;
    int m_rp     = -1;
    int m_out_pos = -1;
    int m_dcnt   = 0;
    bit m_done   = 0;
    bit m_init   = 0;
    int m_old_full, m_old_rp;
    bit m_comp;

    function automatic void model_start();
        for (int i = 0; i < 64; i++) m_rd_blk[i] = m_pix.pop_front();
        m_rp = 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init = 1;
            m_part.delete();
            m_pix.delete();
            m_full    = 0;
            m_rp      = -1;
            m_out_pos = -1;
            m_dcnt    = 0;
            m_done    = 0;
        end else if (m_init) begin
            m_old_full = m_full;
            m_old_rp   = m_rp;
            m_comp     = 0;
            m_out_pos  = m_old_rp;
            m_out_blk  = m_rd_blk;
            if (s_valid && m_old_full < 2) begin
                m_part.push_back(int'(s_data));
                if (m_part.size() == 64) begin
                    m_comp = 1;
                    foreach (m_part[i]) m_pix.push_back(m_part[i]);
                    m_part.delete();
                end
            end
            if (m_old_rp < 0) begin
                if (m_old_full > 0) model_start();
            end else if (m_old_rp < 127) begin
                m_rp = m_old_rp + 1;
            end else begin
                m_full--;
                if (m_old_full - 1 + int'(m_comp) > 0) model_start();
                else m_rp = -1;
            end
            m_full += int'(m_comp);
            if (dct_valid) begin
                if (m_dcnt == 63) begin
                    m_dcnt = 0;
                    m_done = 1;
                end else begin
                    m_dcnt++;
                    m_done = 0;
                end
            end else begin
                m_done = 0;
            end
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    int  e_i, e_k;
    logic [7:0] e_x;
    bit  e_load, e_sel, e_feed;
    int  run = 0, max_run = 0;
    bit  watch_a5 = 0;
    int  a5_seen = 0, a5_bad = 0;

    always @(negedge clk) begin
        if (m_init) begin
            if (m_out_pos >= 0) begin
                e_i    = m_out_pos % 64;
                e_k    = e_i % 8;
                e_x    = 8'(m_out_blk[(e_i / 8) * 8 + col_order[e_k]]);
                e_load = (e_k == 0);
                e_sel  = (m_out_pos >= 64);
                e_feed = 1;
            end else begin
                e_x = 8'h00; e_load = 0; e_sel = 0; e_feed = 0;
            end
            check("s_ready",     32'(s_ready),        32'(!rst && m_full < 2));
            check("feed_active", 32'(feed_active),    32'(e_feed));
            check("dct_x",       32'(dct_x),          32'(e_x));
            check("dct_load",    32'(dct_load),       32'(e_load));
            check("sumDiffSel",  32'(dct_sumDiffSel), 32'(e_sel));
            check("block_done",  32'(block_done),     32'(m_done));
            check("busy",        32'(busy),           32'(m_full > 0 || m_rp >= 0));
        end
        if (feed_active === 1'b1) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (watch_a5 && feed_active === 1'b1) begin
            a5_seen++;
            if (dct_x !== 8'hA5) a5_bad++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_pixel(input logic [7:0] d, output int waits);
        s_data  = d;
        s_valid = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && waits < 1000) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 1000) note_timeout("handshake");
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int mode, input logic [7:0] c, input bit gap,
                              output int first_wait, output int first_cyc, output int last_cyc);
        int w;
        logic [7:0] d;
        first_wait = -1;
        first_cyc  = 0;
        last_cyc   = 0;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       d = 8'(i);
                1:       d = 8'($urandom);
                default: d = c;
            endcase
            push_pixel(d, w);
            if (w > 0 && first_wait < 0) first_wait = i;
            if (i == 0) first_cyc = cyc;
            if (i == 63) last_cyc = cyc;
            if (gap && i < 63) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || feed_active !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) note_timeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s_valid   = 1'b0;
        dct_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Hand-computed expectations for a block whose pixel values equal their index.
    task automatic check_first10();
        int n;
        int exp10[10] = '{0, 7, 1, 6, 2, 5, 3, 4, 8, 15};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (feed_active !== 1'b1 && n < 20);
        check("first_latency", n, 3);
        for (int i = 0; i < 10; i++) begin
            check("first_x",    32'(dct_x),          exp10[i]);
            check("first_load", 32'(dct_load),       32'(i % 8 == 0));
            check("first_sel",  32'(dct_sumDiffSel), 0);
            if (i < 9) @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    int fw, fw2, fw3, fc, lc, t_done, pulses, w;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; dct_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(s_ready), 1);
        check("busy_after_rst",  32'(busy), 0);
        check("feed_after_rst",  32'(feed_active), 0);

        // One block, pixel = index, valid held.
        send_block(0, 8'h00, 1'b0, fw, fc, lc);
        s_valid = 1'b0;
        check("blk1_no_stall", fw, -1);
        check_first10();
        wait_idle();

        // Three blocks streamed back to back.
        do_reset();
        max_run = 0;
        send_block(1, 8'h00, 1'b0, fw, fc, lc);
        send_block(1, 8'h00, 1'b0, fw2, fc, lc);
        send_block(1, 8'h00, 1'b0, fw3, fc, lc);
        s_valid = 1'b0;
        check("stream_blk1_no_stall", fw, -1);
        check("stream_blk2_no_stall", fw2, -1);
        check("stream_stall_at_129th", fw3, 0);
        wait_idle();
        check("stream_run_len", max_run, 384);

        // Valid toggling every cycle.
        do_reset();
        send_block(0, 8'h00, 1'b1, fw, fc, lc);
        s_valid = 1'b0;
        check("toggle_fill_span", lc - fc, 126);
        check_first10();
        wait_idle();

        // Reset with one block buffered and 30 pixels of the next accepted.
        do_reset();
        send_block(2, 8'h11, 1'b0, fw, fc, lc);
        for (int i = 0; i < 30; i++) push_pixel(8'(i), w);
        s_valid = 1'b0;
        do_reset();
        watch_a5 = 1;
        a5_seen = 0;
        a5_bad = 0;
        send_block(2, 8'hA5, 1'b0, fw, fc, lc);
        s_valid = 1'b0;
        wait_idle();
        watch_a5 = 0;
        check("a5_foreign_samples", a5_bad, 0);
        check("a5_sample_count", a5_seen, 128);

        // Completion pulses with dct_valid held for 130 cycles.
        do_reset();
        dct_valid = 1'b1;
        pulses = 0;
        for (int j = 1; j <= 130; j++) begin
            @(posedge clk);
            #1;
            if (j == 130) dct_valid = 1'b0;
            check("done_at_edge", 32'(block_done), 32'(j == 64 || j == 128));
            if (block_done === 1'b1) pulses++;
        end
        @(posedge clk);
        #1;
        check("done_after_stop", 32'(block_done), 0);
        check("done_pulse_count", pulses, 2);

        // Next block's last write lands on the edge the current DIFF pass ends.
        do_reset();
        max_run = 0;
        send_block(1, 8'h00, 1'b0, fw, fc, lc);
        t_done = lc;
        s_valid = 1'b0;
        repeat (65) @(posedge clk);
        #1;
        send_block(1, 8'h00, 1'b0, fw, fc, lc);
        s_valid = 1'b0;
        check("coincide_setup", lc - t_done, 129);
        check("coincide_no_stall", fw, -1);
        wait_idle();
        check("coincide_run_len", max_run, 256);
        send_block(1, 8'h00, 1'b0, fw, fc, lc);
        s_valid = 1'b0;
        wait_idle();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_valid   = ($urandom % 3) != 0;
            s_data    = 8'($urandom);
            dct_valid = ($urandom % 2) != 0;
            @(posedge clk);
            #1;
        end
        s_valid   = 1'b0;
        dct_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
